// File: rtl/apb_mgr_arbiter.sv
// apb_mgr_arbiter: round-robin arbiter sharing one APB subordinate segment between two managers.
// Optional ACCESS-phase timeout compiled in with APB_ARB_TIMEOUT_EN.
module apb_mgr_arbiter #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [1:0]             mgr_psel_i,
    input  logic [1:0]             mgr_penable_i,
    input  logic [1:0]             mgr_pwrite_i,
    input  logic [2*AddrWidth-1:0] mgr_paddr_i,
    input  logic [2*DataWidth-1:0] mgr_pwdata_i,
    output logic [2*DataWidth-1:0] mgr_prdata_o,
    output logic [1:0]             mgr_pready_o,
    output logic [1:0]             mgr_pslverr_o,
    output logic                   sub_psel_o,
    output logic                   sub_penable_o,
    output logic                   sub_pwrite_o,
    output logic [AddrWidth-1:0]   sub_paddr_o,
    output logic [DataWidth-1:0]   sub_pwdata_o,
    input  logic [DataWidth-1:0]   sub_prdata_i,
    input  logic                   sub_pready_i,
    input  logic                   sub_pslverr_i,
    output logic                   grant_o,
    output logic                   busy_o
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e                 state_q, state_d;
    logic                   grant_q, grant_d, last_q, last_d, pwrite_q, pwrite_d;
    logic [AddrWidth-1:0]   paddr_q, paddr_d;
    logic [DataWidth-1:0]   pwdata_q, pwdata_d;
    logic                   win, done, tout;
    logic                   unused_penable;

    assign unused_penable = ^mgr_penable_i;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles);
    logic [CntW-1:0] cnt_q, cnt_d;

    assign tout  = state_q == ACCESS && !sub_pready_i && cnt_q == CntW'(TimeoutCycles - 1);
    assign cnt_d = state_q == SETUP ? '0 :
                   (state_q == ACCESS && !sub_pready_i) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk_i) cnt_q <= !rst_ni ? '0 : cnt_d;
`else
    localparam int unused_timeout = TimeoutCycles;
    assign tout = 1'b0;
`endif

    // On a tie the manager not served last wins.
    assign win  = &mgr_psel_i ? ~last_q : mgr_psel_i[1];
    assign done = state_q == ACCESS && (sub_pready_i || tout);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        if (state_q == IDLE && |mgr_psel_i) begin
            state_d  = SETUP;
            grant_d  = win;
            pwrite_d = mgr_pwrite_i[win];
            paddr_d  = mgr_paddr_i[win*AddrWidth +: AddrWidth];
            pwdata_d = mgr_pwdata_i[win*DataWidth +: DataWidth];
        end
        if (state_q == SETUP) state_d = ACCESS;
        if (done) begin
            state_d = IDLE;
            last_d  = grant_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
        end
    end

    assign sub_psel_o    = state_q != IDLE;
    assign sub_penable_o = state_q == ACCESS;
    assign sub_pwrite_o  = pwrite_q;
    assign sub_paddr_o   = paddr_q;
    assign sub_pwdata_o  = pwdata_q;
    assign busy_o        = state_q != IDLE;
    assign grant_o       = grant_q;

    // A timeout completion forces an error with zero read data.
    always_comb begin
        mgr_pready_o  = '0;
        mgr_pslverr_o = '0;
        mgr_prdata_o  = '0;
        if (done) begin
            mgr_pready_o[grant_q]                        = 1'b1;
            mgr_pslverr_o[grant_q]                       = sub_pready_i ? sub_pslverr_i : 1'b1;
            mgr_prdata_o[grant_q*DataWidth +: DataWidth] = sub_pready_i ? sub_prdata_i : '0;
        end
    end
endmodule

// File: tb/tb_apb_mgr_arbiter.sv
// tb_apb_mgr_arbiter: directed self-checking bench for apb_mgr_arbiter.
module tb_apb_mgr_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic [1:0]  psel = '0, penable = '0, pwrite = '0;
    logic [63:0] paddr = '0, pwdata = '0, prdata;
    logic [1:0]  pready, pslverr;
    logic        sub_psel, sub_penable, sub_pwrite;
    logic [31:0] sub_paddr, sub_pwdata;
    logic [31:0] sub_prdata = '0;
    logic        sub_pready = 1'b0, sub_pslverr = 1'b0;
    logic        grant, busy;
    int          checks = 0, errors = 0;

    always #5 clk_i = ~clk_i;

    apb_mgr_arbiter #(.AddrWidth(32), .DataWidth(32), .TimeoutCycles(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .mgr_psel_i(psel), .mgr_penable_i(penable), .mgr_pwrite_i(pwrite),
        .mgr_paddr_i(paddr), .mgr_pwdata_i(pwdata), .mgr_prdata_o(prdata),
        .mgr_pready_o(pready), .mgr_pslverr_o(pslverr),
        .sub_psel_o(sub_psel), .sub_penable_o(sub_penable), .sub_pwrite_o(sub_pwrite),
        .sub_paddr_o(sub_paddr), .sub_pwdata_o(sub_pwdata),
        .sub_prdata_i(sub_prdata), .sub_pready_i(sub_pready), .sub_pslverr_i(sub_pslverr),
        .grant_o(grant), .busy_o(busy)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; psel = '0; pwrite = '0; paddr = '0; pwdata = '0;
        sub_pready = 1'b0; sub_pslverr = 1'b0; sub_prdata = '0;
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        logic [135:0] all_out;
        do_reset();
        mid();
        all_out = {prdata, pready, pslverr, sub_psel, sub_penable, sub_pwrite, sub_paddr, sub_pwdata, grant, busy};
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %h exp 0", all_out); end
    endtask

    task automatic test_single_write();
        do_reset();
        psel = 2'b01; pwrite = 2'b01; paddr[31:0] = 32'h0000_3000; pwdata[31:0] = 32'hDEAD_BEEF; sub_pready = 1'b1;
        mid();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_c0_busy: got %b exp 0", busy); end
        tick(); mid();
        checks++;
        if ({sub_psel, sub_penable, sub_pwrite, pready} !== 5'b10100)
            begin errors++; $display("FAIL single_c1_ctrl: got %b exp 10100", {sub_psel, sub_penable, sub_pwrite, pready}); end
        checks++;
        if ({sub_paddr, sub_pwdata} !== {32'h0000_3000, 32'hDEAD_BEEF})
            begin errors++; $display("FAIL single_c1_addr_data: got %h %h exp 00003000 deadbeef", sub_paddr, sub_pwdata); end
        tick(); mid();
        checks++;
        if ({sub_psel, sub_penable, pready, pslverr} !== 6'b110100)
            begin errors++; $display("FAIL single_c2_done: got %b exp 110100", {sub_psel, sub_penable, pready, pslverr}); end
        tick(); psel = '0; mid();
        checks++;
        if ({busy, sub_psel, pready} !== 4'b0000) begin errors++; $display("FAIL single_c3_idle: got %b exp 0000", {busy, sub_psel, pready}); end
    endtask

    task automatic test_round_robin();
        do_reset();
        psel = 2'b11; pwrite = 2'b01; paddr = {32'h0000_0200, 32'h0000_0100}; sub_pready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mid();
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL rr%0d_idle_busy: got %b exp 0", k, busy); end
            tick(); mid();
            checks++;
            if (grant !== k[0]) begin errors++; $display("FAIL rr%0d_grant: got %b exp %b", k, grant, k[0]); end
            checks++;
            if (sub_paddr !== (k[0] ? 32'h200 : 32'h100)) begin errors++; $display("FAIL rr%0d_paddr: got %h", k, sub_paddr); end
            tick(); mid();
            checks++;
            if (pready !== (k[0] ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr%0d_pready: got %b", k, pready); end
            tick();
        end
        psel = '0;
    endtask

    task automatic test_wait_states();
        do_reset();
        psel = 2'b10; pwrite = 2'b00; paddr = {32'h0000_0400, 32'h0000_0500};
        sub_prdata = 32'h1234_5678; sub_pslverr = 1'b1;
        tick(); mid();
        checks++;
        if ({sub_pwrite, sub_paddr} !== {1'b0, 32'h400}) begin errors++; $display("FAIL wait_c1_addr: got %b %h exp 0 400", sub_pwrite, sub_paddr); end
        tick(); mid();
        checks++;
        if ({sub_penable, pready} !== 3'b100) begin errors++; $display("FAIL wait_c2: got %b exp 100", {sub_penable, pready}); end
        tick(); psel = 2'b11; mid();
        checks++;
        if ({grant, pready} !== 3'b100) begin errors++; $display("FAIL wait_c3: got %b exp 100", {grant, pready}); end
        tick(); mid();
        checks++;
        if (pready !== 2'b00) begin errors++; $display("FAIL wait_c4_pready: got %b exp 00", pready); end
        tick(); sub_pready = 1'b1; mid();
        checks++;
        if ({pready, pslverr} !== 4'b1010) begin errors++; $display("FAIL wait_c5_resp: got %b exp 1010", {pready, pslverr}); end
        checks++;
        if (prdata !== 64'h1234_5678_0000_0000) begin errors++; $display("FAIL wait_c5_prdata: got %h exp 1234567800000000", prdata); end
        tick(); psel = 2'b01; sub_pslverr = 1'b0; mid();
        checks++;
        if ({busy, pready} !== 3'b000) begin errors++; $display("FAIL wait_c6_idle: got %b exp 000", {busy, pready}); end
        tick(); mid();
        checks++;
        if ({busy, grant, sub_paddr} !== {2'b10, 32'h500}) begin errors++; $display("FAIL wait_pending_grant: got %b %b %h exp 1 0 500", busy, grant, sub_paddr); end
        tick(); mid();
        checks++;
        if ({pready, pslverr} !== 4'b0100) begin errors++; $display("FAIL wait_pending_resp: got %b exp 0100", {pready, pslverr}); end
        tick(); psel = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        psel = 2'b10; paddr = {32'h0000_0600, 32'h0000_0700};
        tick(); tick(); rst_ni = 1'b0; mid();
        checks++;
        if ({sub_penable, pready} !== 3'b100) begin errors++; $display("FAIL rstmid_c2: got %b exp 100", {sub_penable, pready}); end
        tick(); rst_ni = 1'b1; psel = 2'b11; mid();
        checks++;
        if ({busy, sub_psel, sub_penable, pready} !== 5'b00000)
            begin errors++; $display("FAIL rstmid_c3_cleared: got %b exp 00000", {busy, sub_psel, sub_penable, pready}); end
        tick(); mid();
        checks++;
        if ({busy, grant, sub_paddr} !== {2'b10, 32'h700}) begin errors++; $display("FAIL rstmid_first_tie: got %b %b %h exp 1 0 700", busy, grant, sub_paddr); end
        tick(); sub_pready = 1'b1; mid();
        checks++;
        if (pready !== 2'b01) begin errors++; $display("FAIL rstmid_resp: got %b exp 01", pready); end
        tick(); psel = '0;
    endtask

`ifdef APB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        psel = 2'b01; sub_prdata = 32'hFFFF_FFFF;
        tick(); tick();
        for (int c = 2; c <= 4; c++) begin
            mid();
            checks++;
            if (pready !== 2'b00) begin errors++; $display("FAIL tout_c%0d_early: got %b exp 00", c, pready); end
            tick();
        end
        mid();
        checks++;
        if ({pready, pslverr, prdata} !== {4'b0101, 64'h0}) begin errors++; $display("FAIL tout_c5_resp: got %b %b %h exp 01 01 0", pready, pslverr, prdata); end
        tick(); psel = '0; mid();
        checks++;
        if ({busy, sub_psel} !== 2'b00) begin errors++; $display("FAIL tout_c6_idle: got %b exp 00", {busy, sub_psel}); end
    endtask
`else
    task automatic test_long_stall();
        do_reset();
        psel = 2'b01; sub_prdata = 32'hCAFE_F00D;
        tick(); tick();
        for (int c = 2; c <= 1001; c++) begin
            mid();
            checks++;
            if ({busy, pready} !== 3'b100) begin errors++; $display("FAIL stall_c%0d: got %b exp 100", c, {busy, pready}); end
            tick();
        end
        sub_pready = 1'b1; mid();
        checks++;
        if ({pready, pslverr, prdata[31:0]} !== {4'b0100, 32'hCAFE_F00D}) begin errors++; $display("FAIL stall_c1002_resp: got %b %b %h", pready, pslverr, prdata[31:0]); end
        tick(); psel = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_wait_states();
        test_reset_mid();
`ifdef APB_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_long_stall();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
